psw_sync_debounce: RTL and testbench

- Front-end for the board push switches.
- Synchronises and debounces 20 raw switch inputs.
- Emits one-clock press pulses on psw_out[19:0], which the downstream view/mode control consumes (bits 4, 9, 14, 19 select step/mem/io views).
- Also exports the debounced level of each switch for blocks that need hold state.

---
 rtl/psw_pkg.sv | 19 +
 rtl/psw_deb_cell.sv | 92 +++++++++
 rtl/psw_sync_debounce.sv | 81 ++++++++
 tb/tb_psw_sync_debounce.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/psw_pkg.sv
// Shared definitions for the push-switch front-end and the downstream view/mode control.
package psw_pkg;

    localparam int NUM_SW = 20;

    typedef logic [NUM_SW-1:0] psw_vec_t;

    // Switch bit positions consumed by the view/mode control
    localparam int SW_STEP_TGL = 4;
    localparam int SW_STEP_RST = 9;
    localparam int SW_MEM_TGL  = 14;
    localparam int SW_IO_TGL   = 19;

    // Width of a counter that must hold the values 0..n-1
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/psw_deb_cell.sv
// One debounce channel: sample history, stable level and press pulse.
// With PSW_REPEAT_EN defined, a held level also produces auto-repeat pulses.
module psw_deb_cell
    import psw_pkg::*;
#(
    parameter int DEB_LEN      = 4
`ifdef PSW_REPEAT_EN
    ,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic din,
    output logic level,
    output logic pulse
);

    logic [DEB_LEN-1:0] hist_q, hist_d;
    logic               level_q, level_d;
    logic               pulse_q, pulse_d;
    logic               rpt_hit;

    // The level decision looks at the history before this tick's shift
    always_comb begin
        hist_d  = hist_q;
        level_d = level_q;
        if (tick) begin
            hist_d = {hist_q[DEB_LEN-2:0], din};
            if (hist_q == '1) begin
                level_d = 1'b1;
            end else if (hist_q == '0) begin
                level_d = 1'b0;
            end
        end
        pulse_d = (tick & level_d & ~level_q) | rpt_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q  <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

`ifdef PSW_REPEAT_EN
    localparam int RW = cnt_w(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_DELAY + REPEAT_RATE);

    logic [RW-1:0] rpt_q, rpt_d, rpt_inc;

    // After the first repeat the counter folds back so it cycles every REPEAT_RATE ticks
    always_comb begin
        rpt_d   = rpt_q;
        rpt_inc = rpt_q + 1'b1;
        rpt_hit = 1'b0;
        if (!level_d) begin
            rpt_d = '0;
        end else if (tick && level_q) begin
            rpt_d = rpt_inc;
            if (rpt_inc == RPT_FIRST) begin
                rpt_hit = 1'b1;
            end else if (rpt_inc == RPT_NEXT) begin
                rpt_hit = 1'b1;
                rpt_d   = RPT_FIRST;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`else
    assign rpt_hit = 1'b0;
`endif

    assign level = level_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/psw_sync_debounce.sv
// Push-switch front-end: polarity fix, 2-flop sync, sample prescaler and per-switch debounce.
// Define PSW_REPEAT_EN to enable auto-repeat pulses on held switches.
module psw_sync_debounce
    import psw_pkg::*;
#(
    parameter int NUM_SW       = 20,
    parameter int SAMPLE_DIV   = 50000,
    parameter int DEB_LEN      = 4,
    parameter int ACTIVE_LOW   = 1,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] psw_in,
    output logic [NUM_SW-1:0] psw_out,
    output logic [NUM_SW-1:0] psw_level,
    output logic              sample_tick
);

    if (SAMPLE_DIV < 2) begin : g_bad_div
        $error("SAMPLE_DIV must be at least 2");
    end
    if (DEB_LEN < 2) begin : g_bad_len
        $error("DEB_LEN must be at least 2");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_rpt
        $error("REPEAT_DELAY and REPEAT_RATE must be at least 1");
    end

    localparam int CW = cnt_w(SAMPLE_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);

    logic [NUM_SW-1:0] sync1_q, sync1_d;
    logic [NUM_SW-1:0] sync2_q, sync2_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              tick_q, tick_d;

    // tick_d looks at the next count so the registered tick lines up with count == SAMPLE_DIV-1
    always_comb begin
        sync1_d = (ACTIVE_LOW != 0) ? ~psw_in : psw_in;
        sync2_d = sync1_q;
        cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        tick_d  = (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
        end
    end

    for (genvar i = 0; i < NUM_SW; i++) begin : g_cell
        psw_deb_cell #(
            .DEB_LEN      (DEB_LEN)
`ifdef PSW_REPEAT_EN
            ,
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
`endif
        ) u_cell (
            .clk   (clk),
            .rst_n (rst),
            .tick  (tick_q),
            .din   (sync2_q[i]),
            .level (psw_level[i]),
            .pulse (psw_out[i])
        );
    end

    assign sample_tick = tick_q;

endmodule

// File: tb/tb_psw_sync_debounce.sv
// Bench for psw_sync_debounce: reset, table rows, bounce, mid-press reset, repeat and random traffic.
module tb_psw_sync_debounce;
    import psw_pkg::*;

    localparam int N   = NUM_SW;
    localparam int DIV = 4;
    localparam int DL  = 3;
    localparam int RD  = 5;
    localparam int RR  = 2;

    typedef struct {
        psw_vec_t press;
        psw_vec_t exp_level;
        int       exp_pulses;
    } row_t;

    logic     clk = 1'b0;
    logic     rst = 1'b0;
    psw_vec_t psw_in = '1;
    psw_vec_t psw_out;
    psw_vec_t psw_level;
    logic     sample_tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pulses = 0;

    // Reference model: sync delay line, sample clock, run-length debounce, hold counters
    psw_vec_t m_s1, m_s2, m_level, m_pulse;
    logic     m_tick;
    int       m_edges;
    logic     m_run_val [N];
    int       m_run_len [N];
    int       m_hold    [N];

    always #5 clk = ~clk;

    psw_sync_debounce #(
        .NUM_SW       (N),
        .SAMPLE_DIV   (DIV),
        .DEB_LEN      (DL),
        .ACTIVE_LOW   (1),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .psw_in      (psw_in),
        .psw_out     (psw_out),
        .psw_level   (psw_level),
        .sample_tick (sample_tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s1    = '0;
        m_s2    = '0;
        m_level = '0;
        m_pulse = '0;
        m_tick  = 1'b0;
        m_edges = 0;
        for (int i = 0; i < N; i++) begin
            m_run_val[i] = 1'b0;
            m_run_len[i] = DL;
            m_hold[i]    = 0;
        end
    endtask

    task automatic model_edge(input psw_vec_t pressed);
        m_pulse = '0;
        if (m_tick) begin
            for (int i = 0; i < N; i++) begin
                logic was;
                was = m_level[i];
                if (m_run_len[i] >= DL) m_level[i] = m_run_val[i];
                if (m_level[i] && !was) begin
                    m_pulse[i] = 1'b1;
                    m_hold[i]  = 0;
                end else if (!m_level[i]) begin
                    m_hold[i] = 0;
                end else begin
                    m_hold[i]++;
`ifdef PSW_REPEAT_EN
                    if (m_hold[i] == RD || (m_hold[i] > RD && (m_hold[i] - RD) % RR == 0))
                        m_pulse[i] = 1'b1;
`endif
                end
                if (m_s2[i] == m_run_val[i]) begin
                    if (m_run_len[i] < DL) m_run_len[i]++;
                end else begin
                    m_run_val[i] = m_s2[i];
                    m_run_len[i] = 1;
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = pressed;
        m_edges++;
        m_tick = (m_edges % DIV == DIV - 1);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_edge(~psw_in);
        cyc++;
        #1;
        pulses += $countones(psw_out);
        check("sample_tick", sample_tick, m_tick);
        check("psw_level", psw_level, m_level);
        check("psw_out", psw_out, m_pulse);
    endtask

    task automatic press(input psw_vec_t p);
        psw_in = ~p;
    endtask

    initial begin
        row_t     rows [6];
        psw_vec_t b4, b9, b14, b19;
        int       nt, first_tick, first_pulse, both_seen;
        logic     found;
        int       ptimes [$];

        b4  = psw_vec_t'(1) << SW_STEP_TGL;
        b9  = psw_vec_t'(1) << SW_STEP_RST;
        b14 = psw_vec_t'(1) << SW_MEM_TGL;
        b19 = psw_vec_t'(1) << SW_IO_TGL;
        rows[0] = '{press: b4,        exp_level: b4,        exp_pulses: 1};
        rows[1] = '{press: '0,        exp_level: '0,        exp_pulses: 0};
        rows[2] = '{press: b14 | b19, exp_level: b14 | b19, exp_pulses: 2};
        rows[3] = '{press: b9,        exp_level: b9,        exp_pulses: 1};
        rows[4] = '{press: b4 | b14,  exp_level: b4 | b14,  exp_pulses: 2};
        rows[5] = '{press: '0,        exp_level: '0,        exp_pulses: 0};

        // Reset with inputs released, then with every switch pressed
        model_reset();
        repeat (3) step();
        check("rst_out", psw_out, 0);
        check("rst_level", psw_level, 0);
        check("rst_tick", sample_tick, 0);
        press('1);
        repeat (3) step();
        check("rst_out_pressed", psw_out, 0);
        check("rst_level_pressed", psw_level, 0);
        press('0);
        rst = 1'b1;
        nt = 0;
        first_tick = -1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (sample_tick) begin
                nt++;
                if (first_tick < 0) first_tick = k;
            end
        end
        check("tick_count", nt, 3);
        check("tick_first", first_tick, 3);

        // Table rows: each window is 20 clocks, long enough for a full debounce
        for (int r = 0; r < 6; r++) begin
            press(rows[r].press);
            pulses = 0;
            both_seen = 0;
            for (int k = 0; k < 20; k++) begin
                step();
                if (psw_out[SW_MEM_TGL] && psw_out[SW_IO_TGL]) both_seen++;
            end
            check($sformatf("row%0d_level", r), psw_level, rows[r].exp_level);
            check($sformatf("row%0d_pulses", r), pulses, rows[r].exp_pulses);
            if (r == 2) check("row2_same_cycle", both_seen, 1);
        end

        // Bounce on bit 9 every 5 clocks, then a clean hold
        pulses = 0;
        for (int k = 0; k < 60; k++) begin
            if (k % 5 == 0) psw_in[SW_STEP_RST] = ~psw_in[SW_STEP_RST];
            step();
        end
        check("bounce_pulses", pulses, 0);
        check("bounce_level", psw_level[SW_STEP_RST], 0);
        press(b9);
        pulses = 0;
        repeat (20) step();
        check("bounce_hold_pulses", pulses, 1);
        check("bounce_hold_level", psw_level[SW_STEP_RST], 1);
        press('0);
        repeat (24) step();
        check("bounce_release_level", psw_level, 0);

        // Reset mid-debounce, then reset during the pulse, switch held throughout
        press(b4);
        repeat (8) step();
        rst = 1'b0;
        model_reset();
        #1;
        check("midrst_out", psw_out, 0);
        check("midrst_level", psw_level, 0);
        check("midrst_tick", sample_tick, 0);
        repeat (3) step();
        rst = 1'b1;
        found = 1'b0;
        first_pulse = -1;
        for (int k = 1; k <= 20 && !found; k++) begin
            step();
            if (psw_out[SW_STEP_TGL]) begin
                found = 1'b1;
                first_pulse = k;
            end
        end
        check("midrst_pulse_seen", found, 1);
        check("midrst_latency_ok", (first_pulse >= 12 && first_pulse <= 19), 1);
        rst = 1'b0;
        model_reset();
        #1;
        check("pulse_cut", psw_out, 0);
        check("pulse_cut_level", psw_level, 0);
        repeat (2) step();
        rst = 1'b1;
        pulses = 0;
        repeat (20) step();
        check("held_thru_rst_pulses", pulses, 1);
        press('0);
        repeat (24) step();
        check("held_thru_rst_release", psw_level, 0);

        // Long hold on bit 4 (40 sample ticks)
        press(b4);
        for (int k = 0; k < 160; k++) begin
            step();
            if (psw_out[SW_STEP_TGL]) ptimes.push_back(cyc);
        end
        press('0);
        for (int k = 0; k < 24; k++) begin
            step();
            if (psw_out[SW_STEP_TGL]) ptimes.push_back(cyc);
        end
`ifdef PSW_REPEAT_EN
        check("repeat_count", ptimes.size(), 19);
        for (int k = 1; k < ptimes.size(); k++)
            check($sformatf("repeat_gap%0d", k), ptimes[k] - ptimes[k-1], (k == 1) ? RD * DIV : RR * DIV);
`else
        check("single_pulse_count", ptimes.size(), 1);
`endif
        check("long_hold_release", psw_level, 0);

        // Random independent toggling on all channels
        for (int k = 0; k < 1500; k++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 23) == 0) psw_in[b] = ~psw_in[b];
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
